// File: rtl/snes_rom_responder.sv
// Cartridge-side SNES ROM responder: fetches the addressed byte over a req/ack
// memory port and presents it after ACCESS_CYCLES. Optional ROM_PREFETCH_EN adds next-address prefetch.
module snes_rom_responder #(
  parameter int         ACCESS_CYCLES = 4,
  parameter logic [7:0] IDLE_DATA     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [19:0] address,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  localparam logic [3:0] ACC = 4'(ACCESS_CYCLES);

  state_t      state, state_d;
  logic [19:0] cur_addr;
  logic        cur_ok, got, reissue;
  logic [3:0]  cnt;
  logic [7:0]  rbuf;
  logic        ack, change, fetch_ack, go_valid, pf_hit;

`ifdef ROM_PREFETCH_EN
  logic [19:0] pf_addr;
  logic [7:0]  pf_buf;
  logic        pf_ok, pf_inflight, pf_issued, pf_issue;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    ack       = mem_req && mem_ack;
    change    = enable && (!cur_ok || (address != cur_addr));
    pf_hit    = 1'b0;
    fetch_ack = ack && !reissue;
`ifdef ROM_PREFETCH_EN
    pf_hit    = pf_ok && (address == pf_addr);
    fetch_ack = ack && !reissue && !pf_inflight;
    pf_issue  = enable && !change && (state == VALID) && !mem_req && !pf_issued;
`endif
    go_valid  = (state == FETCH) && (got || fetch_ack) && (cnt >= ACC);
    state_d   = state;
    if (!enable)       state_d = IDLE;
    else if (change)   state_d = FETCH;
    else if (go_valid) state_d = VALID;
  end

  // NOTE: rbuf is pure data qualified by got, so it is kept out of reset.
  always_ff @(posedge clk) begin
    if (fetch_ack) rbuf <= mem_rdata;
`ifdef ROM_PREFETCH_EN
    else if (change && pf_hit) rbuf <= pf_buf;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      data       <= IDLE_DATA;
      data_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      cur_addr   <= '0;
      cur_ok     <= 1'b0;
      got        <= 1'b0;
      cnt        <= '0;
      reissue    <= 1'b0;
    end else begin
      state <= state_d;
      if (ack) begin
        mem_req <= 1'b0;
        reissue <= 1'b0;
      end
      if (!enable) begin
        data       <= IDLE_DATA;
        data_valid <= 1'b0;
        cur_ok     <= 1'b0;
        if (mem_req && !mem_ack) reissue <= 1'b1;
      end else if (change) begin
        cur_addr   <= address;
        cur_ok     <= 1'b1;
        cnt        <= 4'd1;
        got        <= pf_hit;
        data       <= IDLE_DATA;
        data_valid <= 1'b0;
        if (!pf_hit) begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= address;
          end else if (!mem_ack) begin
            reissue <= 1'b1;
          end
          // A request acked on this same edge is dropped; the FETCH re-request picks up next edge.
        end
      end else if (state == FETCH) begin
        if (cnt < ACC) cnt <= cnt + 4'd1;
        if (fetch_ack) got <= 1'b1;
        if (go_valid) begin
          data       <= fetch_ack ? mem_rdata : rbuf;
          data_valid <= 1'b1;
        end
        if (!mem_req && !got) begin
          mem_req  <= 1'b1;
          mem_addr <= cur_addr;
        end
`ifdef ROM_PREFETCH_EN
      end else if (pf_issue) begin
        mem_req  <= 1'b1;
        mem_addr <= cur_addr + 20'd1;
`endif
      end
    end
  end

`ifdef ROM_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (ack && pf_inflight) pf_buf <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_addr     <= '0;
      pf_ok       <= 1'b0;
      pf_inflight <= 1'b0;
      pf_issued   <= 1'b0;
    end else begin
      if (ack && pf_inflight) begin
        pf_inflight <= 1'b0;
        if (!reissue) pf_ok <= 1'b1;
      end
      if (!enable || change) begin
        pf_ok     <= 1'b0;
        pf_issued <= 1'b0;
      end else if (pf_issue) begin
        pf_issued   <= 1'b1;
        pf_inflight <= 1'b1;
        pf_addr     <= cur_addr + 20'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_snes_rom_responder.sv
// Scoreboard bench for snes_rom_responder: stimulus pushes expected bytes and
// their presentation edge; a monitor pops on each rising data_valid.
module tb_snes_rom_responder;

  localparam int         AC   = 4;
  localparam logic [7:0] IDLE = 8'hFF;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [19:0] address;
  logic [7:0]  data;
  logic        data_valid, mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  typedef struct {
    logic [7:0] data;
    int         at_edge;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rom[int];
  int         tests = 0, fails = 0, cyc = 0;
  int         ack_delay = 1, req_age = 0, e0 = 0;
  logic       prev_dv = 1'b0;

  snes_rom_responder #(.ACCESS_CYCLES(AC), .IDLE_DATA(IDLE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .address(address),
    .data(data), .data_valid(data_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input int at);
    exp_t e;
    e.data    = d;
    e.at_edge = at;
    sb.push_back(e);
  endtask

  task automatic settle();
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) @(negedge clk);
    check("settle_idle", mem_req, 0);
  endtask

  // Backing memory: acks ack_delay edges after the request first appears.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        req_age++;
        if (req_age >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rom.exists(int'(mem_addr)) ? rom[int'(mem_addr)] : mem_addr[7:0];
          req_age   = 0;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1 && !prev_dv) begin
        check("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("sb_data", data, e.data);
          check("sb_latency", cyc, e.at_edge);
        end
      end
      if (data_valid !== 1'b1) check("open_bus", data, IDLE);
      prev_dv = (data_valid === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; address = '0;
    rom[32'h10] = 8'hA5; rom[32'h30] = 8'h3C; rom[32'h20] = 8'h11; rom[32'h21] = 8'h22;
    rom[32'h40] = 8'h77; rom[32'h50] = 8'h5E; rom[32'hFFFFF] = 8'h9E; rom[32'h0] = 8'hC3;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rst_data", data, IDLE);
      check("rst_valid", data_valid, 0);
      check("rst_req", mem_req, 0);
    end
    check("rst_mem_addr", mem_addr, 0);

    // Early ack: data still waits for the full access time.
    ack_delay = 1; enable = 1'b1; address = 20'h00010; e0 = cyc + 1;
    push(8'hA5, e0 + AC);
    tick(1); check("a_req", mem_req, 1); check("a_addr", mem_addr, 20'h00010);
    tick(1); check("a_req_drop", mem_req, 0);
    tick(2); check("a_not_yet", data_valid, 0);
    tick(3); check("a_hold", data_valid, 1);
`ifndef ROM_PREFETCH_EN
    check("a_no_refetch", mem_req, 0);
`endif

    // Late ack: data appears on the ack edge.
    settle(); ack_delay = 7; address = 20'h00030; e0 = cyc + 1;
    push(8'h3C, e0 + 7);
    tick(1); check("b_addr", mem_addr, 20'h00030);
    tick(6); check("b_req_held", mem_req, 1); check("b_not_yet", data_valid, 0);
    tick(3);

    // Change while the first request is outstanding: old data discarded.
    settle(); ack_delay = 2; address = 20'h00020; e0 = cyc + 1;
    tick(1); check("c_addr0", mem_addr, 20'h00020);
    address = 20'h00021;
    tick(1); check("c_addr_held", mem_addr, 20'h00020); check("c_req_held", mem_req, 1);
    tick(1); check("c_req_gap", mem_req, 0);
    tick(1); check("c_reissue", mem_req, 1); check("c_addr1", mem_addr, 20'h00021);
    push(8'h22, e0 + 5);
    tick(4);

    // Ack exactly at the access-time boundary.
    settle(); ack_delay = AC; address = 20'h00050; e0 = cyc + 1;
    push(8'h5E, e0 + AC);
    tick(7);

    // Reset in the middle of a fetch, then a clean fetch after release.
    settle(); ack_delay = 5; address = 20'h00040;
    tick(2); reset = 1'b1;
    tick(1);
    check("r_req", mem_req, 0); check("r_data", data, IDLE); check("r_valid", data_valid, 0);
    reset = 1'b0; ack_delay = 1; e0 = cyc + 1;
    push(8'h77, e0 + AC);
    tick(1); check("r_new_req", mem_req, 1); check("r_new_addr", mem_addr, 20'h00040);
    tick(6);

`ifdef ROM_PREFETCH_EN
    settle(); ack_delay = 1; address = 20'hFFFFF; e0 = cyc + 1;
    push(8'h9E, e0 + AC);
    tick(AC + 2); check("pf_req", mem_req, 1); check("pf_wrap_addr", mem_addr, 0);
    settle(); address = 20'h00000; e0 = cyc + 1;
    push(8'hC3, e0 + AC);
    for (int i = 0; i < AC; i++) begin
      tick(1); check("pf_no_req", mem_req, 0);
    end
    tick(2);
`endif

    // Enable low drops back to open bus.
    enable = 1'b0;
    tick(1); check("off_data", data, IDLE); check("off_valid", data_valid, 0);
    tick(3); check("off_req", mem_req, 0);

    tick(3);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
